// File: rtl/sensor_cond_pkg.sv
// Shared types and default thresholds for the A2D sensor conditioning block.
package sensor_cond_pkg;

  typedef enum logic [1:0] {StIdle, StCapture, StAccum, StUpdate} sc_state_t;

  localparam logic [11:0] LowBattThreshDef = 12'hA98;
  localparam logic [11:0] LowBattHystDef   = 12'h040;
  localparam logic [11:0] BrakeThreshDef   = 12'h800;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/sensor_cond_ema_filt.sv
// Exponential moving average with 1/2^Shift weight; first enabled step seeds the accumulator.
module ema_filt #(
  parameter int unsigned Shift = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_seed,
  input  logic [11:0] i_sample,
  output logic [11:0] o_avg
);

  localparam int unsigned AccW = 12 + Shift;

  logic [AccW-1:0] r_acc;
  logic [AccW-1:0] w_acc_next;

  // Subtract-before-add keeps the result within AccW bits for any 12b sample.
  always_comb begin
    w_acc_next = r_acc;
    if (i_en) begin
      if (i_seed) w_acc_next = {i_sample, {Shift{1'b0}}};
      else        w_acc_next = r_acc - (r_acc >> Shift) + {{Shift{1'b0}}, i_sample};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_acc <= '0;
    else       r_acc <= w_acc_next;
  end

  assign o_avg = r_acc[AccW-1:Shift];

endmodule

// File: rtl/sensor_cond.sv
// Samples A2D readings on a periodic tick and produces filtered current/torque,
// hysteretic low-battery and debounced brake, all published with one strobe.
module sensor_cond
  import sensor_cond_pkg::*;
#(
  parameter bit          FAST_SIM        = 1'b0,
  parameter int unsigned TORQUE_SHIFT    = 3,
  parameter logic [11:0] LOW_BATT_THRESH = LowBattThreshDef,
  parameter logic [11:0] LOW_BATT_HYST   = LowBattHystDef,
  parameter logic [11:0] BRAKE_THRESH    = BrakeThreshDef
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_batt,
  input  logic [11:0] i_curr,
  input  logic [11:0] i_brake,
  input  logic [11:0] i_torque,
  output logic [11:0] o_avg_curr,
  output logic [11:0] o_avg_torque,
  output logic        o_low_batt,
  output logic        o_brake_n,
  output logic        o_sample_vld
);

  localparam int unsigned TickW = FAST_SIM ? 8 : 16;

  sc_state_t         r_state, w_state_next;
  logic [TickW-1:0]  r_tick_cnt;
  logic              w_tick;
  logic [11:0]       r_s_batt, r_s_curr, r_s_brake, r_s_torque;
  logic [11:0]       r_curr_buf [4];
  logic [13:0]       r_curr_sum;
  logic              r_seeded;
  logic [1:0]        r_brake_cnt, w_brake_cnt_next;
  logic [12:0]       w_clr_level;
  logic [11:0]       w_ema_avg;
  logic [11:0]       r_avg_curr, r_avg_torque;
  logic              r_low_batt, r_brake_n, r_sample_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_tick_cnt <= '0;
    else       r_tick_cnt <= r_tick_cnt + TickW'(1);
  end

  assign w_tick = &r_tick_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Ticks outside IDLE fall through and are dropped.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_tick) w_state_next = StCapture;
      StCapture: w_state_next = StAccum;
      StAccum:   w_state_next = StUpdate;
      StUpdate:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_batt   <= '0;
      r_s_curr   <= '0;
      r_s_brake  <= '0;
      r_s_torque <= '0;
    end else if (r_state == StCapture) begin
      r_s_batt   <= i_batt;
      r_s_curr   <= i_curr;
      r_s_brake  <= i_brake;
      r_s_torque <= i_torque;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_curr_sum <= '0;
      r_seeded   <= 1'b0;
      for (int i = 0; i < 4; i++) r_curr_buf[i] <= '0;
    end else if (r_state == StAccum) begin
      r_curr_sum    <= r_curr_sum - {2'b00, r_curr_buf[3]} + {2'b00, r_s_curr};
      r_curr_buf[0] <= r_s_curr;
      for (int i = 1; i < 4; i++) r_curr_buf[i] <= r_curr_buf[i-1];
      r_seeded      <= 1'b1;
    end
  end

  ema_filt #(
    .Shift (TORQUE_SHIFT)
  ) u_ema_filt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (r_state == StAccum),
    .i_seed   (!r_seeded),
    .i_sample (r_s_torque),
    .o_avg    (w_ema_avg)
  );

  assign w_clr_level      = {1'b0, LOW_BATT_THRESH} + {1'b0, LOW_BATT_HYST};
  assign w_brake_cnt_next = (r_s_brake < BRAKE_THRESH) ? sat_inc2(r_brake_cnt) : 2'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_avg_curr   <= '0;
      r_avg_torque <= '0;
      r_low_batt   <= 1'b0;
      r_brake_n    <= 1'b1;
      r_brake_cnt  <= '0;
      r_sample_vld <= 1'b0;
    end else begin
      r_sample_vld <= (r_state == StUpdate);
      if (r_state == StUpdate) begin
        r_avg_curr   <= r_curr_sum[13:2];
        r_avg_torque <= w_ema_avg;
        r_brake_cnt  <= w_brake_cnt_next;
        r_brake_n    <= (w_brake_cnt_next < 2'd2);
        if (r_s_batt < LOW_BATT_THRESH)                r_low_batt <= 1'b1;
        else if ({1'b0, r_s_batt} >= w_clr_level)      r_low_batt <= 1'b0;
      end
    end
  end

  assign o_avg_curr   = r_avg_curr;
  assign o_avg_torque = r_avg_torque;
  assign o_low_batt   = r_low_batt;
  assign o_brake_n    = r_brake_n;
  assign o_sample_vld = r_sample_vld;

endmodule

// File: tb/tb_sensor_cond.sv
// Randomized and directed checks of sensor_cond against a behavioural model.
module tb_sensor_cond;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] batt, curr, brake, torque;
  logic [11:0] avg_curr, avg_torque;
  logic        low_batt, brake_n, sample_vld;

  int unsigned k = 0;
  int          errors = 0;
  int          checks = 0;

  int m_hist [4];
  int m_acc, m_consec, m_avg_curr, m_avg_torque;
  bit m_seeded, m_low, m_brake_n;
  logic exp_vld;

  sensor_cond #(
    .FAST_SIM (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_batt       (batt),
    .i_curr       (curr),
    .i_brake      (brake),
    .i_torque     (torque),
    .o_avg_curr   (avg_curr),
    .o_avg_torque (avg_torque),
    .o_low_batt   (low_batt),
    .o_brake_n    (brake_n),
    .o_sample_vld (sample_vld)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the sample strobe lands at 3 mod 256 once a tick has occurred.
  always @(posedge clk) k <= rst ? 0 : k + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    m_acc = 0; m_seeded = 0; m_low = 0; m_consec = 0;
    m_avg_curr = 0; m_avg_torque = 0; m_brake_n = 1;
  endtask

  task automatic model_step(input int b, input int c, input int br, input int t);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = c;
    m_avg_curr = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
    if (!m_seeded) begin
      m_acc = t * 8;
      m_seeded = 1;
    end else begin
      m_acc = m_acc - m_acc / 8 + t;
    end
    m_avg_torque = m_acc / 8;
    if (b < 'hA98) m_low = 1;
    else if (b >= 'hA98 + 'h40) m_low = 0;
    m_consec = (br < 'h800) ? m_consec + 1 : 0;
    m_brake_n = (m_consec < 2);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      exp_vld = 1'b0;
    end else begin
      exp_vld = (k >= 256) && (k % 256 == 3);
      if (exp_vld) model_step(int'(batt), int'(curr), int'(brake), int'(torque));
    end
    check("sample_vld", sample_vld, exp_vld);
    check("avg_curr", avg_curr, m_avg_curr);
    check("avg_torque", avg_torque, m_avg_torque);
    check("low_batt", low_batt, m_low);
    check("brake_n", brake_n, m_brake_n);
  end

  task automatic wait_vld();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((k >= 256) && (k % 256 == 3)) && n < 600);
    if (n >= 600) begin
      errors++;
      $display("FAIL wait_vld: no sample slot within %0d clks", n);
    end
    #1;
  endtask

  task automatic set_in(input logic [11:0] b, input logic [11:0] c, input logic [11:0] br,
                        input logic [11:0] t);
    batt = b; curr = c; brake = br; torque = t;
  endtask

  initial begin
    int n;
    set_in(12'hB00, 12'h400, 12'h100, 12'h800);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    wait_vld();
    check("lit_curr_1", avg_curr, 12'h100);
    check("lit_torque_seed", avg_torque, 12'h800);
    check("lit_low_b00", low_batt, 1'b0);
    check("lit_brake_1st", brake_n, 1'b1);

    set_in(12'hA97, 12'h400, 12'hFFF, 12'h000);
    wait_vld();
    check("lit_curr_2", avg_curr, 12'h200);
    check("lit_torque_2", avg_torque, 12'h700);
    check("lit_low_a97", low_batt, 1'b1);
    check("lit_brake_rel", brake_n, 1'b1);

    set_in(12'hAC0, 12'h400, 12'h100, 12'h000);
    wait_vld();
    check("lit_curr_3", avg_curr, 12'h300);
    check("lit_torque_3", avg_torque, 12'h620);
    check("lit_low_ac0", low_batt, 1'b1);
    check("lit_brake_one", brake_n, 1'b1);

    set_in(12'hAD8, 12'h400, 12'h100, 12'h000);
    wait_vld();
    check("lit_curr_4", avg_curr, 12'h400);
    check("lit_torque_4", avg_torque, 12'h55C);
    check("lit_low_ad8", low_batt, 1'b0);
    check("lit_brake_two", brake_n, 1'b0);

    set_in(12'hA98, 12'h400, 12'hFFF, 12'h000);
    wait_vld();
    check("lit_curr_5", avg_curr, 12'h400);
    check("lit_low_a98", low_batt, 1'b0);
    check("lit_brake_off", brake_n, 1'b1);

    // Reset while the datapath is accumulating; the next sample must reseed the EMA.
    set_in(12'hB00, 12'h200, 12'hFFF, 12'h300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((k >= 256) && (k % 256 == 1)) && n < 600);
    if (n >= 600) begin
      errors++;
      $display("FAIL wait_accum: no accumulate slot within %0d clks", n);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_avg_curr", avg_curr, 12'h000);
    check("rst_avg_torque", avg_torque, 12'h000);
    check("rst_brake_n", brake_n, 1'b1);
    check("rst_vld", sample_vld, 1'b0);
    #1 rst = 1'b0;
    wait_vld();
    check("lit_reseed", avg_torque, 12'h300);
    check("lit_curr_rst", avg_curr, 12'h080);

    for (int i = 0; i < 40; i++) begin
      set_in(($urandom_range(0, 1) == 1) ? 12'($urandom_range(12'hA50, 12'hAF0))
                                         : 12'($urandom),
             12'($urandom),
             ($urandom_range(0, 2) != 0) ? 12'($urandom_range(0, 12'h7FF))
                                         : 12'($urandom_range(12'h800, 12'hFFF)),
             12'($urandom));
      wait_vld();
    end

    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
